// File: rtl/sha2ind_pkg.sv
// sha2ind_pkg: state encoding and padding layout shared by the SHA-2 input sequencer.
package sha2ind_pkg;

    typedef enum logic [8:0] {
        S_CLR   = 9'b000000001,
        S_IDLE  = 9'b000000010,
        S_MSG   = 9'b000000100,
        S_WAITM = 9'b000001000,
        S_PAD   = 9'b000010000,
        S_WAITP = 9'b000100000,
        S_ZERO  = 9'b001000000,
        S_LEN   = 9'b010000000,
        S_WAITL = 9'b100000000
    } state_t;

    // The length word occupies the tail of the final block; zeros stop just before it.
    localparam int LEN_WORDS = 1;

    function automatic int last_idx(input int dec_w);
        return (1 << dec_w) - 1;
    endfunction

endpackage

// File: rtl/sha2indctrl_if.sv
// sha2indctrl_if: word-input, datapath-strobe and block-output signals of the input sequencer.
interface sha2indctrl_if #(
    parameter int DEC_W  = 3,
    parameter int BCNT_W = 16
);
    logic              pkt_valid, pkt_last, pkt_rdy;
    logic [DEC_W-1:0]  idx;
    logic              st_pkt, clr, pad_pkt, zero_pkt, mgln_pkt;
    logic              blk_valid, blk_last, blk_ack, busy;
    logic [BCNT_W-1:0] blk_cnt;

    modport master (
        output pkt_valid, pkt_last, idx, blk_ack,
        input  pkt_rdy, st_pkt, clr, pad_pkt, zero_pkt, mgln_pkt, blk_valid, blk_last, blk_cnt, busy
    );

    modport slave (
        input  pkt_valid, pkt_last, idx, blk_ack,
        output pkt_rdy, st_pkt, clr, pad_pkt, zero_pkt, mgln_pkt, blk_valid, blk_last, blk_cnt, busy
    );
endinterface

// File: rtl/sha2ind_bcnt.sv
// sha2ind_bcnt: per-message block counter; clr wins over count-up.
module sha2ind_bcnt #(
    parameter int BCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              c_up_i,
    output logic [BCNT_W-1:0] cnt_o
);
    logic [BCNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : c_up_i ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/sha2indctrl.sv
// sha2indctrl: sequences message words, pad, zero and length words into 8-word blocks
// and hands each finished block to the compression stage.
module sha2indctrl
    import sha2ind_pkg::*;
#(
    parameter int DEC_W  = 3,
    parameter int BCNT_W = 16
) (
    input logic         clk,
    input logic         rst,
    sha2indctrl_if.slave bus
);
    localparam logic [DEC_W-1:0] LAST = DEC_W'(last_idx(DEC_W));
    localparam logic [DEC_W-1:0] PRE  = DEC_W'(last_idx(DEC_W) - LEN_WORDS);

    state_t            state_q, state_d;
    logic              pp_q, pp_d;
    logic              in_st, acc, at_last, at_pre, wait_st;
    logic [BCNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLR;
            pp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pp_q    <= pp_d;
        end
    end

    // pp remembers that the last word filled a block, so padding follows the ack.
    always_comb begin
        in_st   = state_q == S_IDLE || state_q == S_MSG;
        acc     = in_st && bus.pkt_valid;
        at_last = bus.idx == LAST;
        at_pre  = bus.idx == PRE;
        pp_d    = acc && at_last ? bus.pkt_last : pp_q;
        state_d = state_q;
        case (state_q)
            S_CLR:         state_d = S_IDLE;
            S_IDLE, S_MSG: if (acc) state_d = at_last ? S_WAITM : bus.pkt_last ? S_PAD : S_MSG;
            S_WAITM:       if (bus.blk_ack) state_d = pp_q ? S_PAD : S_MSG;
            S_PAD:         state_d = at_last ? S_WAITP : at_pre ? S_LEN : S_ZERO;
            S_WAITP:       if (bus.blk_ack) state_d = S_ZERO;
            S_ZERO:        if (at_pre) state_d = S_LEN;
            S_LEN:         state_d = S_WAITL;
            S_WAITL:       if (bus.blk_ack) state_d = S_CLR;
            default:       state_d = S_CLR;
        endcase
    end

    always_comb begin
        wait_st       = state_q inside {S_WAITM, S_WAITP, S_WAITL};
        bus.pkt_rdy   = !rst && in_st;
        bus.st_pkt    = !rst && (acc || state_q inside {S_PAD, S_ZERO, S_LEN});
        bus.pad_pkt   = !rst && state_q == S_PAD;
        bus.zero_pkt  = !rst && state_q == S_ZERO;
        bus.mgln_pkt  = !rst && state_q == S_LEN;
        bus.clr       = !rst && state_q == S_CLR;
        bus.blk_valid = !rst && wait_st;
        bus.blk_last  = !rst && state_q == S_WAITL;
        bus.busy      = !rst && !(state_q inside {S_CLR, S_IDLE});
        bus.blk_cnt   = rst ? '0 : cnt;
    end

    sha2ind_bcnt #(.BCNT_W(BCNT_W)) u_bcnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (bus.clr),
        .c_up_i(bus.blk_ack && wait_st),
        .cnt_o (cnt)
    );
endmodule

// File: tb/tb_sha2indctrl.sv
// tb_sha2indctrl: random message lengths, gaps and ack delays checked against a
// word-stream model (N words, pad, zeros, length, grouped into 8-word blocks).
module tb_sha2indctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sha2indctrl_if #(.DEC_W(3), .BCNT_W(16)) bus ();

    sha2indctrl #(.DEC_W(3), .BCNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Datapath word counter: cleared by clr, advanced by each store.
    always @(posedge clk) bus.idx <= (rst || bus.clr) ? 3'd0 : bus.st_pkt ? bus.idx + 3'd1 : bus.idx;

    function automatic logic [8:0] outs();
        return {bus.pkt_rdy, bus.st_pkt, bus.pad_pkt, bus.zero_pkt, bus.mgln_pkt,
                bus.clr, bus.blk_valid, bus.blk_last, bus.busy};
    endfunction

    task automatic check_vec(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s outs got %b exp %b (rdy st pad zero mgln clr bv bl busy)", tag, got, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [15:0] got, input int exp);
        checks++;
        assert (got === 16'(exp)) else begin
            errors++;
            $error("FAIL %s blk_cnt got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            rst = 1'b1;
            bus.pkt_valid = 1'($urandom);
            bus.pkt_last  = 1'($urandom);
            bus.blk_ack   = 1'($urandom);
            #1;
            check_vec($sformatf("rst_%0d", i), outs(), 9'b0);
            check_cnt($sformatf("rst_cnt_%0d", i), bus.blk_cnt, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.pkt_valid = 1'($urandom);
        bus.blk_ack   = 1'($urandom);
        #1;
        check_vec("clr_after_rst", outs(), 9'b000001000);
        check_cnt("clr_after_rst_cnt", bus.blk_cnt, 0);
    endtask

    task automatic run_msg(input int n, input bit gap, input int hold, input bit stray, input bit abort);
        int total = ((n + 9) / 8) * 8;
        int pos = 0;
        int acked = 0;
        int wcyc = 0;
        int budget = 0;
        int kind;
        bit bv, st;
        logic [8:0] e;
        while (acked * 8 < total) begin
            if (++budget > 3000) begin
                checks++;
                errors++;
                $error("FAIL timeout n%0d got pos %0d acked %0d exp total %0d", n, pos, acked, total);
                return;
            end
            @(posedge clk); #1;
            bv = pos > 0 && pos % 8 == 0 && pos / 8 > acked;
            bus.pkt_valid = bv ? 1'b1 : pos < n ? (!gap || $urandom_range(0, 2) != 0) : 1'($urandom);
            bus.pkt_last  = (bus.pkt_valid && pos < n) ? (pos == n - 1) : 1'($urandom);
            bus.blk_ack   = bv ? (wcyc >= hold) : (stray && $urandom_range(0, 3) == 0);
            #1;
            kind = pos < n ? 0 : pos == n ? 1 : pos == total - 1 ? 3 : 2;
            st = !bv && (pos < n ? bus.pkt_valid : 1'b1);
            e = {!bv && pos < n, st, st && kind == 1, st && kind == 2, st && kind == 3,
                 1'b0, bv, bv && pos == total, pos > 0};
            check_vec($sformatf("n%0d_p%0d", n, pos), outs(), e);
            check_cnt($sformatf("n%0d_p%0d_cnt", n, pos), bus.blk_cnt, acked);
            if (abort && st && kind == 2) return;
            wcyc = bv ? wcyc + 1 : 0;
            if (bv && bus.blk_ack) acked++;
            if (st) pos++;
        end
        @(posedge clk); #1;
        bus.pkt_valid = 1'($urandom);
        bus.pkt_last  = 1'($urandom);
        bus.blk_ack   = 1'($urandom);
        #1;
        check_vec($sformatf("n%0d_clr", n), outs(), 9'b000001000);
        check_cnt($sformatf("n%0d_final_cnt", n), bus.blk_cnt, total / 8);
    endtask

    initial begin
        bus.pkt_valid = 1'b0;
        bus.pkt_last  = 1'b0;
        bus.blk_ack   = 1'b0;
        do_reset();
        run_msg(1, 0, 0, 0, 0);
        run_msg(6, 0, 0, 0, 0);
        run_msg(7, 0, 0, 0, 0);
        run_msg(8, 0, 5, 0, 0);
        run_msg(5, 1, 1, 1, 0);
        run_msg(16, 1, 3, 1, 0);
        run_msg(9, 0, 0, 0, 1);
        do_reset();
        for (int i = 0; i < 12; i++)
            run_msg($urandom_range(1, 40), 1'($urandom), $urandom_range(0, 4), 1'($urandom), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sha2indctrl.md
Name: sha2indctrl

Overview:
- Sequencer for the SHA-2 input datapath (64-bit packet register file, word counter `idx`, message-length register, pad/zero/length packet mux).
- Accepts message words over a valid/ready handshake and generates `st_pkt`, `clr`, `pad_pkt`, `zero_pkt` and `mgln_pkt`.
- Appends the padding word, zero words and length word after the last message word.
- Presents each completed 8-word block to the compression stage over a valid/ack handshake and stalls the input while a block is pending.

Parameters:
- DEC_W, 3, width of datapath `idx`; words per block = 2**DEC_W; LAST_IDX = 2**DEC_W-1.
- BCNT_W, 16, width of the per-message block counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- pkt_valid  in  1  message word available on datapath `pkt`.
- pkt_last  in  1  qualifies the current word as last of the message.
- pkt_rdy  out  1  controller accepts a word this cycle.
- idx  in  DEC_W  datapath counter value (slot written by the current `st_pkt`).
- st_pkt  out  1  store strobe to datapath.
- clr  out  1  clears datapath counter and length register.
- pad_pkt  out  1  select padding word.
- zero_pkt  out  1  select zero word.
- mgln_pkt  out  1  select message-length word.
- blk_valid  out  1  `blk` holds a complete block.
- blk_last  out  1  with `blk_valid`: final block of the message.
- blk_ack  in  1  consumer has taken the block.
- blk_cnt  out  BCNT_W  blocks acked in the current message.
- busy  out  1  message in progress (first word accepted through final clr).

Behaviour:
- States: CLR, IDLE, MSG, WAITM, PAD, WAITP, ZERO, LEN, WAITL. State is registered; all outputs are decoded combinationally from state plus `pkt_valid` and `idx`.
- Reset: while `rst`=1, state=CLR and `blk_cnt`=0; `st_pkt`, `pad_pkt`, `zero_pkt`, `mgln_pkt`, `pkt_rdy`, `blk_valid`, `blk_last` and `busy` are all 0. Reset mid-message abandons the message; the partially filled block is discarded.
- CLR: `clr`=1 for exactly one cycle and `blk_cnt` is cleared. Next state is IDLE. This is the first cycle after reset release and the cycle after every final block ack.
- IDLE and MSG:
  - `pkt_rdy`=1; accept = `pkt_valid` & `pkt_rdy`; `st_pkt` = accept, with pad/zero/mgln all 0.
  - On accept, the next state is decided from `idx` as follows.
  - Not last, `idx`<LAST_IDX: go to MSG.
  - Not last, `idx`=LAST_IDX: go to WAITM; pending-pad flag = 0.
  - Last, `idx`<LAST_IDX: go to PAD.
  - Last, `idx`=LAST_IDX: go to WAITM; pending-pad flag = 1.
  - No accept: hold state (bubbles are allowed). `busy`=0 in IDLE and 1 everywhere else except CLR.
- WAITM: `blk_valid`=1, `blk_last`=0, `pkt_rdy`=0, no strobes. On `blk_ack`, `blk_cnt`+1 and go to PAD if the pending-pad flag is set, else MSG.
- PAD: `st_pkt`=`pad_pkt`=1 for one cycle. Next state:
  - `idx`=LAST_IDX: WAITP.
  - `idx`=LAST_IDX-1: LEN.
  - Otherwise: ZERO.
- WAITP: same outputs as WAITM. On `blk_ack`, `blk_cnt`+1 and go to ZERO.
- ZERO: `st_pkt`=`zero_pkt`=1 each cycle. When `idx`=LAST_IDX-1, go to LEN.
- LEN: `st_pkt`=`mgln_pkt`=1 for one cycle, written at `idx`=LAST_IDX. Go to WAITL.
- WAITL: `blk_valid`=`blk_last`=1. On `blk_ack`, `blk_cnt`+1 and go to CLR.
- Mutual exclusion:
  - At most one of pad/zero/mgln is high, and only when `st_pkt`=1.
  - `clr` and `st_pkt` are never high together.
- Handshakes:
  - `blk_ack` outside the WAIT states is ignored.
  - `blk_ack` high in the first WAIT cycle completes in one cycle.
  - `pkt_valid` while `pkt_rdy`=0 is ignored; the word stays with the producer.
  - `pkt_last` is sampled only on accept.
- Block count: blocks per message = ceil((N+2)/8) for N message words. `blk_cnt` wraps modulo 2**BCNT_W.

Decomposition:
- Package `sha2ind_pkg`: state localparams (one-hot), LAST_IDX derivation, padding-sequence constants.
- Sub-module `sha2ind_bcnt`: BCNT_W synchronous up-counter with sync active-high reset, `clr` and `c_up` (= `blk_ack` in a WAIT state). `clr` has priority over `c_up`.

Test Plan:
- Reset, then 1 word with last=1 -> `clr` pulse once after reset; `st_pkt` for word(idx0), pad(idx1), 5 zeros(idx2-6), mgln(idx7); one `blk_valid`&`blk_last`; ack -> `blk_cnt`=1, `clr` pulse, IDLE.
- 6 words, last on 6th -> pad at idx6, no zero cycles, mgln at idx7, single block.
- 7 words -> pad at idx7, `blk_valid` with `blk_last`=0; ack -> 7 zeros (idx0-6), mgln, second block `blk_last`=1, `blk_cnt`=2.
- 8 words -> WAITM after idx7, `pkt_rdy`=0; hold ack 5 cycles with `pkt_valid`=1 -> no `st_pkt`; ack -> pad at idx0, zeros idx1-6, mgln idx7.
- Words with `pkt_valid` gaps plus stray `blk_ack` in MSG -> no extra strobes, `blk_cnt` unchanged.
- Assert `rst` during ZERO -> next cycle all strobes 0, `blk_cnt`=0; after release one `clr` pulse, then IDLE with `pkt_rdy`=1.
